// File: rtl/brownout_reset_seq_if.sv
// Bus between the brownout sequencer and its consumers: comparator flags and
// controls in, reset/status out.
interface brownout_reset_seq_if #(
  parameter int EVT_W = 8
);
  logic             brout;
  logic             vunder;
  logic             ena;
  logic [1:0]       hold_sel;
  logic             clr_flags;
  logic             sys_rst_n;
  logic             vunder_irq;
  logic             bor_flag;
  logic             vunder_flag;
  logic [EVT_W-1:0] bor_count;
  logic [1:0]       state;

  modport master (
    output brout, vunder, ena, hold_sel, clr_flags,
    input  sys_rst_n, vunder_irq, bor_flag, vunder_flag, bor_count, state
  );
  modport slave (
    input  brout, vunder, ena, hold_sel, clr_flags,
    output sys_rst_n, vunder_irq, bor_flag, vunder_flag, bor_count, state
  );
endinterface

// File: rtl/brownout_reset_seq.sv
// Brownout reset sequencer: synchronises comparator flags, holds the system
// reset for a selectable time, and keeps sticky status plus an event count.
module brownout_reset_seq #(
  parameter int HOLD_BASE = 16,
  parameter int CNT_W     = 12,
  parameter int EVT_W     = 8
) (
  input  logic                 osc_ck,
  input  logic                 rst_n,
  brownout_reset_seq_if.slave  bus
);
  localparam logic [1:0] HOLD   = 2'd0;
  localparam logic [1:0] ASSERT = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;

  logic [1:0]       bsync_q, vsync_q;
  logic             brout_s, vunder_s, vprev_q, vrise;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hold_last;
  logic [1:0]       hsel_q, hsel_d, sel_eff;
  logic             init_q;
  logic             srst_q, srst_d;
  logic             irq_q, bflag_q, bflag_d, vflag_q, vflag_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic             bor_evt;

  assign brout_s  = bsync_q[1] & bus.ena;
  assign vunder_s = vsync_q[1] & bus.ena;
  assign vrise    = vunder_s & ~vprev_q;

  // First edge after reset release uses the live select, as if it had been
  // latched at release; later HOLD entries use the value latched on entry.
  assign sel_eff   = init_q ? bus.hold_sel : hsel_q;
  assign hold_last = CNT_W'((HOLD_BASE << {sel_eff, 1'b0}) - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hsel_d  = init_q ? bus.hold_sel : hsel_q;
    srst_d  = srst_q;
    bor_evt = 1'b0;
    case (state_q)
      HOLD: begin
        if (brout_s) begin
          state_d = ASSERT;
          cnt_d   = '0;
          srst_d  = 1'b0;
        end else if (cnt_q == hold_last) begin
          state_d = RUN;
          cnt_d   = '0;
          srst_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ASSERT: begin
        cnt_d  = '0;
        srst_d = 1'b0;
        if (!brout_s) begin
          state_d = HOLD;
          hsel_d  = bus.hold_sel;
        end
      end
      RUN: begin
        if (brout_s) begin
          state_d = ASSERT;
          srst_d  = 1'b0;
          bor_evt = 1'b1;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        srst_d  = 1'b0;
      end
    endcase
  end

  // Set beats clear when both land on the same edge.
  always_comb begin
    bflag_d = bus.clr_flags ? 1'b0 : bflag_q;
    vflag_d = bus.clr_flags ? 1'b0 : vflag_q;
    evt_d   = bus.clr_flags ? '0 : evt_q;
    if (bor_evt) begin
      bflag_d = 1'b1;
      if (bus.clr_flags)          evt_d = EVT_W'(1);
      else if (evt_q != '1)       evt_d = evt_q + EVT_W'(1);
    end
    if (vrise) vflag_d = 1'b1;
  end

  always_ff @(posedge osc_ck or negedge rst_n) begin
    if (!rst_n) begin
      bsync_q <= '0;
      vsync_q <= '0;
      vprev_q <= 1'b0;
      state_q <= HOLD;
      cnt_q   <= '0;
      hsel_q  <= '0;
      init_q  <= 1'b1;
      srst_q  <= 1'b0;
      irq_q   <= 1'b0;
      bflag_q <= 1'b0;
      vflag_q <= 1'b0;
      evt_q   <= '0;
    end else begin
      bsync_q <= {bsync_q[0], bus.brout};
      vsync_q <= {vsync_q[0], bus.vunder};
      vprev_q <= vunder_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hsel_q  <= hsel_d;
      init_q  <= 1'b0;
      srst_q  <= srst_d;
      irq_q   <= vrise;
      bflag_q <= bflag_d;
      vflag_q <= vflag_d;
      evt_q   <= evt_d;
    end
  end

  assign bus.sys_rst_n   = srst_q;
  assign bus.vunder_irq  = irq_q;
  assign bus.bor_flag    = bflag_q;
  assign bus.vunder_flag = vflag_q;
  assign bus.bor_count   = evt_q;
  assign bus.state       = state_q;
endmodule

// File: doc/brownout_reset_seq.md
Name: brownout_reset_seq

Overview:
- Digital sequencer directly downstream of the brownout comparator block, clocked from its RC oscillator output (osc_ck).
- Synchronises the comparator's brownout (out) and undervoltage (vunder) flags.
- Generates a held system reset with selectable hold time, a one-cycle undervoltage interrupt, sticky status flags and a saturating brownout event counter.
- Output consumers are the digital core reset tree and the status register file.

Parameters:
- HOLD_BASE, 16: base reset-hold length in osc_ck cycles; the actual hold is HOLD_BASE << (2*hold_sel).
- CNT_W, 12: hold counter width. HOLD_BASE<<6 must be at most 2^CNT_W.
- EVT_W, 8: width of the brownout event counter.

Ports:
- osc_ck  in  1  clock (from the brownout block's oscillator).
- rst_n  in  1  asynchronous, active-low reset.
- brout  in  1  brownout flag from the comparator (out); asynchronous, high = supply below trip.
- vunder  in  1  undervoltage warning from the comparator; asynchronous, high = under.
- ena  in  1  enable, quasi-static. When 0, brout and vunder are treated as 0 after synchronisation.
- hold_sel  in  2  hold-length select; sampled on entry to HOLD.
- clr_flags  in  1  synchronous clear of bor_flag, vunder_flag and bor_count.
- sys_rst_n  out  1  registered, active-low system reset.
- vunder_irq  out  1  one-cycle pulse on a synchronised vunder rising edge.
- bor_flag  out  1  sticky: a brownout occurred while in RUN.
- vunder_flag  out  1  sticky: a vunder rising edge occurred.
- bor_count  out  EVT_W  saturating count of RUN->ASSERT transitions.
- state  out  2  debug view of FSM state: HOLD=0, ASSERT=1, RUN=2.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=HOLD, hold counter=0, latched hold_sel=hold_sel at release.
  - Synchroniser flops=0, sys_rst_n=0, vunder_irq=0, flags=0, bor_count=0.
- Synchronisers: 2-FF on brout and vunder. Then brout_s = sync(brout)&ena and vunder_s = sync(vunder)&ena.
- Latency:
  - brout high sampled at edge N gives brout_s=1 after edge N+1.
  - The FSM reacts at edge N+2, so sys_rst_n=0 after edge N+2.
- sys_rst_n is a register: 1 only while state==RUN (set on the transition edge).
- hold_len = HOLD_BASE << (2*hold_sel_latched); defaults give 16/64/256/1024.
- FSM (one transition per edge):
  - HOLD: if brout_s then ASSERT. Else if cnt==hold_len-1 then RUN, with cnt cleared and sys_rst_n=1. Else cnt++.
  - ASSERT: cnt held at 0. When brout_s=0, go to HOLD and latch hold_sel.
  - RUN: when brout_s=1, go to ASSERT, set bor_flag and increment bor_count (saturate at 2^EVT_W-1).
- After reset release the block starts in HOLD, so the first sys_rst_n rise comes hold_len cycles later if brout_s stays 0.
- A brout glitch during HOLD returns to ASSERT, and the count restarts from 0 on re-entry. There is no partial-credit hold.
- Edges from HOLD or ASSERT into ASSERT do not set bor_flag or count. Only a drop out of RUN counts.
- vunder:
  - vunder_irq=1 for exactly one cycle when vunder_s rises (registered edge detect, previous value stored).
  - vunder_flag is set on the same edge.
  - vunder does not affect the FSM.
- clr_flags=1 clears bor_flag, vunder_flag and bor_count on the next edge. If a set event happens on the same edge, set wins: the flag becomes 1 and bor_count becomes 1.
- ena 1->0: brout_s and vunder_s fall after the synchroniser. The FSM proceeds HOLD->RUN normally. No vunder_irq is generated on the falling side.
- hold_sel changes outside HOLD entry have no effect until the next entry to HOLD.

Test Plan:
- Power-up: rst_n released with ena=1, brout=0, hold_sel=0 -> sys_rst_n rises exactly 16 cycles after the first edge. state=2, flags=0, bor_count=0.
- Brownout in RUN: brout pulse of 40 cycles -> sys_rst_n low 2 edges after the sample. state=1, bor_flag=1, bor_count=1. After brout falls, sys_rst_n stays low for 2 sync edges plus 16 hold cycles, then returns to 1.
- Glitch during HOLD with hold_sel=1: brout 1-cycle pulse at cnt=30 -> returns to ASSERT, then full 64-cycle hold. bor_count is unchanged.
- Saturation and clear: 300 RUN brownouts -> bor_count=255. clr_flags on the same edge as the 301st event -> bor_flag=1, bor_count=1.
- vunder: vunder rises and stays high for 100 cycles -> exactly one vunder_irq pulse, 2 edges after sampling. vunder_flag=1 until clr_flags. sys_rst_n is unaffected.
- ena=0 with brout=1 and vunder=1 -> FSM reaches RUN after hold_len, no irq, flags stay 0. Asserting rst_n mid-HOLD resets all outputs immediately and the hold restarts.
